// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter with byte FIFO, 8N1 (8E1 when UART_TX_PARITY_EN is defined)
module uart_tx_fifo #(
    parameter int CLK_DIV    = 54,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic             aclk,
    input  logic             BTN_UP,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             UART_TX,
    output logic             tx_busy,
    output logic [FIFO_AW:0] fifo_count
);

    localparam int DEPTH  = 1 << FIFO_AW;
    localparam int BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [BAUD_W-1:0]  BAUD_MAX = BAUD_W'(CLK_DIV - 1);
    localparam logic [TICK_W-1:0]  TICK_MAX = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BAUD_W-1:0]  BAUD_ONE = BAUD_W'(1);
    localparam logic [TICK_W-1:0]  TICK_ONE = TICK_W'(1);
    localparam logic [FIFO_AW:0]   PTR_ONE  = (FIFO_AW + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t              state, state_nx;
    logic [7:0]          mem [DEPTH];
    logic [FIFO_AW:0]    wptr, rptr;
    logic [BAUD_W-1:0]   baud_cnt;
    logic [TICK_W-1:0]   tick_cnt;
    logic [2:0]          bit_idx;
    logic [7:0]          shift;
    logic                tx_q;
    logic                line_nx;
    logic                pop;
    logic                push;
    logic                full;
    logic                empty;
    logic                bit_done;
    logic [7:0]          head;
`ifdef UART_TX_PARITY_EN
    logic                parity_q;
`endif

    // Extra pointer MSB distinguishes full from empty when the index bits match
    assign empty      = (wptr == rptr);
    assign full       = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                        (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
    assign push       = tx_valid && !full;
    assign head       = mem[rptr[FIFO_AW-1:0]];
    assign bit_done   = (baud_cnt == BAUD_MAX) && (tick_cnt == TICK_MAX);

    assign tx_ready   = !full;
    assign fifo_count = wptr - rptr;
    assign tx_busy    = (state != S_IDLE) || !empty;
    assign UART_TX    = tx_q;

    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wptr[FIFO_AW-1:0]] <= tx_data;
        end
    end

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        line_nx  = 1'b1;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    state_nx = S_START;
                end
            end
            S_START: begin
                line_nx = 1'b0;
                if (bit_done) state_nx = S_DATA;
            end
            S_DATA: begin
                line_nx = shift[0];
                if (bit_done && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_nx = S_PARITY;
`else
                    state_nx = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                line_nx = parity_q;
                if (bit_done) state_nx = S_STOP;
            end
`endif
            S_STOP: begin
                // Back-to-back frames: pop on the stop-bit end edge, no idle gap
                if (bit_done) begin
                    if (!empty) begin
                        pop      = 1'b1;
                        state_nx = S_START;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (BTN_UP) begin
            state    <= S_IDLE;
            wptr     <= '0;
            rptr     <= '0;
            baud_cnt <= '0;
            tick_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            tx_q  <= line_nx;
            if (push) wptr <= wptr + PTR_ONE;
            if (pop)  rptr <= rptr + PTR_ONE;

            // Clearing on pop keeps every bit exactly CLK_DIV*OVERSAMPLE clocks
            if (pop || state == S_IDLE) begin
                baud_cnt <= '0;
                tick_cnt <= '0;
            end else if (baud_cnt == BAUD_MAX) begin
                baud_cnt <= '0;
                tick_cnt <= (tick_cnt == TICK_MAX) ? '0 : tick_cnt + TICK_ONE;
            end else begin
                baud_cnt <= baud_cnt + BAUD_ONE;
            end

            if (pop) begin
                shift    <= head;
                bit_idx  <= '0;
`ifdef UART_TX_PARITY_EN
                parity_q <= ^head;
`endif
            end else if (state == S_DATA && bit_done) begin
                shift   <= {1'b0, shift[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

    localparam int BIT_D = 864;
    localparam int BIT   = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
    localparam logic [10:0] FR30 = {1'b1, 1'b0, 8'h30, 1'b0};
`else
    localparam int NBITS = 10;
    localparam logic [10:0] FR30 = {1'b0, 1'b1, 8'h30, 1'b0};
`endif
    localparam int FRAME_D = NBITS * BIT_D;
    localparam int FRAME   = NBITS * BIT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] d_data = '0;
    logic       d_valid = 1'b0;
    logic       d_ready, d_tx, d_busy;
    logic [4:0] d_count;
    logic [7:0] s_data = '0;
    logic       s_valid = 1'b0;
    logic       s_ready, s_tx, s_busy;
    logic [4:0] s_count;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    logic rx_en = 1'b0;
    logic [7:0] rx_byte [$];
    int         rx_start [$];
    logic       rx_frm [$];
    logic       rx_par [$];

    uart_tx_fifo u_def (
        .aclk(clk), .BTN_UP(rst), .tx_data(d_data), .tx_valid(d_valid),
        .tx_ready(d_ready), .UART_TX(d_tx), .tx_busy(d_busy), .fifo_count(d_count)
    );

    uart_tx_fifo #(.CLK_DIV(4), .OVERSAMPLE(4), .FIFO_AW(4)) u_fast (
        .aclk(clk), .BTN_UP(rst), .tx_data(s_data), .tx_valid(s_valid),
        .tx_ready(s_ready), .UART_TX(s_tx), .tx_busy(s_busy), .fifo_count(s_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        s_data  = b;
        s_valid = 1'b1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (s_busy && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_timeout", s_busy, 1'b0);
    endtask

    task automatic wait_rx(input int cnt, input int limit);
        int n = 0;
        while (rx_byte.size() < cnt && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("rx_count", rx_byte.size(), cnt);
    endtask

    task automatic rx_clear();
        rx_byte.delete();
        rx_start.delete();
        rx_frm.delete();
        rx_par.delete();
    endtask

    // Bench-side receiver: samples mid-bit on the falling clock edge
    initial begin
        logic [7:0] b;
        logic sb, pb, stp;
        int st;
        forever begin
            @(negedge clk);
            if (rx_en && s_tx === 1'b0) begin
                st = cyc;
                pb = 1'b0;
                repeat (BIT / 2) @(negedge clk);
                sb = s_tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) @(negedge clk);
                    b[i] = s_tx;
                end
`ifdef UART_TX_PARITY_EN
                repeat (BIT) @(negedge clk);
                pb = s_tx;
`endif
                repeat (BIT) @(negedge clk);
                stp = s_tx;
                rx_byte.push_back(b);
                rx_start.push_back(st);
                rx_frm.push_back(sb == 1'b0 && stp == 1'b1);
                rx_par.push_back(pb);
            end
        end
    end

    initial begin
        int t0, e, r, edges;
        logic [10:0] fr;
        logic prev;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", d_tx, 1'b1);
        check("rst_ready", d_ready, 1'b1);
        check("rst_busy", d_busy, 1'b0);
        check("rst_count", d_count, 5'd0);
        check("rst_fast_tx", s_tx, 1'b1);
        check("rst_fast_count", s_count, 5'd0);
        rst = 1'b0;

        // Single 0x30 frame at default 864 clocks per bit
        d_data  = 8'h30;
        d_valid = 1'b1;
        @(posedge clk);
        #1;
        d_valid = 1'b0;
        t0 = cyc;
        check("push_count", d_count, 5'd1);
        @(posedge clk);
        #1;
        check("t0p1_tx_high", d_tx, 1'b1);
        check("t0p1_popped", d_count, 5'd0);
        @(posedge clk);
        #1;
        check("t0p2_start_low", d_tx, 1'b0);
        fr = FR30;
        for (int k = 0; k < NBITS; k++) begin
            repeat ((k == 0) ? BIT_D / 2 : BIT_D) @(posedge clk);
            #1;
            check($sformatf("frame30_bit%0d", k), d_tx, fr[k]);
        end
        repeat (t0 + FRAME_D - cyc) @(posedge clk);
        #1;
        check("busy_before_end", d_busy, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("busy_cleared", d_busy, 1'b0);

        // Fill to full, drop one, back-to-back loopback of 0x30..0x40
        rx_clear();
        rx_en = 1'b1;
        for (int i = 0; i < 17; i++) push(8'h30 + 8'(i));
        check("full_count", s_count, 5'd16);
        check("full_ready", s_ready, 1'b0);
        push(8'h99);
        check("drop_count", s_count, 5'd16);
        wait_rx(17, 17 * FRAME + 200);
        wait_idle(2 * FRAME);
        repeat (FRAME) @(posedge clk);
        #1;
        check("no_dropped_byte", rx_byte.size(), 17);
        for (int i = 0; i < 17 && i < rx_byte.size(); i++) begin
            check($sformatf("lb_byte%0d", i), rx_byte[i], 8'h30 + 8'(i));
            check($sformatf("lb_frame%0d", i), rx_frm[i], 1'b1);
`ifdef UART_TX_PARITY_EN
            check($sformatf("lb_par%0d", i), rx_par[i], ^(8'h30 + 8'(i)));
`endif
            if (i > 0) check($sformatf("lb_gap%0d", i), rx_start[i] - rx_start[i-1], FRAME);
        end

        // Simultaneous push and pop at fifo_count=5; write pointer has wrapped
        rx_clear();
        push(8'h50);
        e = cyc;
        for (int i = 1; i < 6; i++) push(8'h50 + 8'(i));
        check("five_count", s_count, 5'd5);
        repeat (e + FRAME - cyc) @(posedge clk);
        #1;
        check("pre_pushpop_count", s_count, 5'd5);
        push(8'h56);
        check("pushpop_count", s_count, 5'd5);
        wait_rx(7, 8 * FRAME);
        for (int i = 0; i < 7 && i < rx_byte.size(); i++)
            check($sformatf("wrap_byte%0d", i), rx_byte[i], 8'h50 + 8'(i));
        wait_idle(2 * FRAME);

`ifdef UART_TX_PARITY_EN
        rx_clear();
        push(8'h31);
        push(8'h33);
        wait_rx(2, 3 * FRAME);
        if (rx_byte.size() == 2) begin
            check("par_31", rx_par[0], 1'b1);
            check("par_33", rx_par[1], 1'b0);
            check("par_frame_len", rx_start[1] - rx_start[0], 11 * BIT);
        end
        wait_idle(2 * FRAME);
`endif

        // Reset during data bit 3 of 0x55
        rx_en = 1'b0;
        push(8'h55);
        e = cyc;
        push(8'h66);
        r = e + 2 + 4 * BIT + BIT / 2;
        repeat (r - 1 - cyc) @(posedge clk);
        #1;
        check("bit3_low", s_tx, 1'b0);
        check("pre_rst_count", s_count, 5'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_tx", s_tx, 1'b1);
        check("midrst_count", s_count, 5'd0);
        check("midrst_ready", s_ready, 1'b1);
        check("midrst_busy", s_busy, 1'b0);
        edges = 0;
        prev  = s_tx;
        repeat (3 * FRAME) begin
            @(negedge clk);
            if (s_tx !== prev) edges++;
            prev = s_tx;
        end
        check("midrst_no_edges", edges, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
